// File: rtl/pacman_pkg.sv
// Shared constants, field entry layout and FSM states for the hardware BFS pathfinder.
package pacman_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [2:0] QDIR_NONE   = 3'd4;
    localparam logic [2:0] QDIR_AT_TGT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SEED,
        S_POP,
        S_CHECK,
        S_DONE
    } bfs_state_e;

    typedef struct packed {
        logic       visited;
        logic       is_tgt;
        logic [1:0] dir;
    } field_entry_t;

    // Returns {dx[1:0], dy[1:0]} as 2-bit two's-complement steps.
    function automatic logic [3:0] dir_to_vec(input logic [1:0] d);
        logic [3:0] v;
        case (d)
            DIR_UP:   v = 4'b00_11;
            DIR_LEFT: v = 4'b11_00;
            DIR_DOWN: v = 4'b00_01;
            default:  v = 4'b01_00;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bfs_queue.sv
// Circular FIFO holding packed {y,x} cells of the BFS frontier; DEPTH must be a power of two.
module bfs_queue #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bfs_path_engine.sv
// Breadth-first flood from a target cell; stores per-cell step direction toward the target
// and answers single-cell direction queries with one cycle of latency.
module bfs_path_engine
    import pacman_pkg::*;
#(
    parameter int XB          = 5,
    parameter int YB          = 5,
    parameter int MAP_W       = 28,
    parameter int MAP_H       = 28,
    parameter int QUEUE_DEPTH = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XB-1:0] tgt_x,
    input  logic [YB-1:0] tgt_y,
    output logic [XB-1:0] map_x,
    output logic [YB-1:0] map_y,
    input  logic          map_wall,
    output logic          busy,
    output logic          done,
    output logic          path_valid,
    output logic          overflow,
    input  logic [XB-1:0] qry_x,
    input  logic [YB-1:0] qry_y,
    output logic [2:0]    qry_dir
);

    localparam int AW    = XB + YB;
    localparam int CELLS = 2 ** AW;
    localparam logic [XB:0] X_LIM = (XB+1)'(MAP_W);
    localparam logic [YB:0] Y_LIM = (YB+1)'(MAP_H);

    bfs_state_e    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [XB-1:0] tgt_x_q, tgt_x_d, p_x_q, p_x_d, map_x_q, map_x_d;
    logic [YB-1:0] tgt_y_q, tgt_y_d, p_y_q, p_y_d, map_y_q, map_y_d;
    logic [1:0]    nbr_q, nbr_d;
    logic          path_valid_q, path_valid_d;
    logic          overflow_q, overflow_d;
    logic [2:0]    qry_dir_q, qry_dir_d;

    field_entry_t  field [CELLS];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    field_entry_t  wr_data;
    logic          flood_visited;
    field_entry_t  qry_rd;

    logic          q_push, q_pop, q_full, q_empty;
    logic [AW-1:0] q_push_data, q_pop_data;
    logic [AW-1:0] nxt_cell_pop, nxt_cell_chk;

    function automatic logic in_bounds(input logic [XB-1:0] x, input logic [YB-1:0] y);
        return (x != '0) && ({1'b0, x} < X_LIM) && (y != '0) && ({1'b0, y} < Y_LIM);
    endfunction

    // Out-of-range neighbours are left unwrapped so the bounds test rejects them.
    function automatic logic [AW-1:0] step_cell(input logic [XB-1:0] x, input logic [YB-1:0] y,
                                                 input logic [1:0] d);
        logic [3:0]    v;
        logic [XB-1:0] nx;
        logic [YB-1:0] ny;
        v  = dir_to_vec(d);
        nx = x + {{(XB-2){v[3]}}, v[3:2]};
        ny = y + {{(YB-2){v[1]}}, v[1:0]};
        return {ny, nx};
    endfunction

    bfs_queue #(
        .WIDTH(AW),
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (q_push),
        .push_data(q_push_data),
        .pop      (q_pop),
        .pop_data (q_pop_data),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign flood_visited = field[{map_y_q, map_x_q}].visited;
    assign qry_rd        = field[{qry_y, qry_x}];
    assign nxt_cell_pop  = step_cell(q_pop_data[XB-1:0], q_pop_data[AW-1:XB], DIR_UP);
    assign nxt_cell_chk  = step_cell(p_x_q, p_y_q, nbr_q + 2'd1);

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        tgt_x_d      = tgt_x_q;
        tgt_y_d      = tgt_y_q;
        p_x_d        = p_x_q;
        p_y_d        = p_y_q;
        map_x_d      = map_x_q;
        map_y_d      = map_y_q;
        nbr_d        = nbr_q;
        path_valid_d = path_valid_q;
        overflow_d   = overflow_q;
        wr_en        = 1'b0;
        wr_addr      = clr_addr_q;
        wr_data      = '0;
        q_push       = 1'b0;
        q_push_data  = {tgt_y_q, tgt_x_q};
        q_pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_CLEAR;
                    tgt_x_d      = tgt_x;
                    tgt_y_d      = tgt_y;
                    clr_addr_d   = '0;
                    path_valid_d = 1'b0;
                    overflow_d   = 1'b0;
                end
            end
            S_CLEAR: begin
                wr_en      = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = S_SEED;
                end
            end
            S_SEED: begin
                if (in_bounds(tgt_x_q, tgt_y_q)) begin
                    wr_en   = 1'b1;
                    wr_addr = {tgt_y_q, tgt_x_q};
                    wr_data = '{visited: 1'b1, is_tgt: 1'b1, dir: DIR_UP};
                    q_push  = 1'b1;
                    state_d = S_POP;
                end else begin
                    state_d      = S_DONE;
                    path_valid_d = 1'b1;
                end
            end
            S_POP: begin
                if (q_empty) begin
                    state_d      = S_DONE;
                    path_valid_d = 1'b1;
                end else begin
                    q_pop   = 1'b1;
                    p_x_d   = q_pop_data[XB-1:0];
                    p_y_d   = q_pop_data[AW-1:XB];
                    nbr_d   = DIR_UP;
                    map_x_d = nxt_cell_pop[XB-1:0];
                    map_y_d = nxt_cell_pop[AW-1:XB];
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // Visited is marked even when the push is dropped, so no cell is queued twice.
                if (in_bounds(map_x_q, map_y_q) && !map_wall && !flood_visited) begin
                    wr_en       = 1'b1;
                    wr_addr     = {map_y_q, map_x_q};
                    wr_data     = '{visited: 1'b1, is_tgt: 1'b0, dir: nbr_q + 2'd2};
                    q_push_data = {map_y_q, map_x_q};
                    if (q_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        q_push = 1'b1;
                    end
                end
                nbr_d   = nbr_q + 2'd1;
                map_x_d = nxt_cell_chk[XB-1:0];
                map_y_d = nxt_cell_chk[AW-1:XB];
                if (nbr_q == DIR_RIGHT) begin
                    state_d = S_POP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        qry_dir_d = QDIR_NONE;
        if (!busy && path_valid_q && in_bounds(qry_x, qry_y) && qry_rd.visited) begin
            qry_dir_d = qry_rd.is_tgt ? QDIR_AT_TGT : {1'b0, qry_rd.dir};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            clr_addr_q   <= '0;
            tgt_x_q      <= '0;
            tgt_y_q      <= '0;
            p_x_q        <= '0;
            p_y_q        <= '0;
            map_x_q      <= '0;
            map_y_q      <= '0;
            nbr_q        <= '0;
            path_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            qry_dir_q    <= QDIR_NONE;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            tgt_x_q      <= tgt_x_d;
            tgt_y_q      <= tgt_y_d;
            p_x_q        <= p_x_d;
            p_y_q        <= p_y_d;
            map_x_q      <= map_x_d;
            map_y_q      <= map_y_d;
            nbr_q        <= nbr_d;
            path_valid_q <= path_valid_d;
            overflow_q   <= overflow_d;
            qry_dir_q    <= qry_dir_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            field[wr_addr] <= wr_data;
        end
    end

    assign busy       = (state_q == S_CLEAR) || (state_q == S_SEED) ||
                        (state_q == S_POP)   || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign path_valid = path_valid_q;
    assign overflow   = overflow_q;
    assign map_x      = map_x_q;
    assign map_y      = map_y_q;
    assign qry_dir    = qry_dir_q;

endmodule

// File: tb/tb_bfs_path_engine.sv
// Directed bench for bfs_path_engine: open box, blocking wall, out-of-bounds target,
// tiny-queue overflow, ignored starts, mid-flood reset and path walks.
module tb_bfs_path_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a, start_b;
    logic [4:0] tgt_x, tgt_y;
    logic [4:0] qry_x, qry_y;
    logic [4:0] map_x_a, map_y_a, map_x_b, map_y_b;
    logic       wall_a, wall_b;
    logic       busy_a, done_a, path_valid_a, overflow_a;
    logic       busy_b, done_b, path_valid_b, overflow_b;
    logic [2:0] qry_dir_a, qry_dir_b;

    int tests = 0;
    int fails = 0;
    int wall_mode = 0;
    int ovf_at_start;
    int cycles, steps, d;

    always #5 clk = ~clk;

    function automatic logic wall_at(input logic [4:0] x, input logic [4:0] y, input int mode);
        if (x == 5'd0 || y == 5'd0 || x >= 5'd28 || y >= 5'd28) return 1'b1;
        if (mode == 1 && x == 5'd10) return 1'b1;
        return 1'b0;
    endfunction

    assign wall_a = wall_at(map_x_a, map_y_a, wall_mode);
    assign wall_b = wall_at(map_x_b, map_y_b, wall_mode);

    bfs_path_engine dut_a (
        .clk(clk), .reset(reset), .start(start_a), .tgt_x(tgt_x), .tgt_y(tgt_y),
        .map_x(map_x_a), .map_y(map_y_a), .map_wall(wall_a),
        .busy(busy_a), .done(done_a), .path_valid(path_valid_a), .overflow(overflow_a),
        .qry_x(qry_x), .qry_y(qry_y), .qry_dir(qry_dir_a)
    );

    bfs_path_engine #(.QUEUE_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .tgt_x(tgt_x), .tgt_y(tgt_y),
        .map_x(map_x_b), .map_y(map_y_b), .map_wall(wall_b),
        .busy(busy_b), .done(done_b), .path_valid(path_valid_b), .overflow(overflow_b),
        .qry_x(qry_x), .qry_y(qry_y), .qry_dir(qry_dir_b)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        tests++;
        assert (obs >= lo && obs <= hi) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Called right after a negedge; returns with done visible, cycles = edges since start.
    task automatic run_flood(input bit sel, input int x, input int y, output int n);
        tgt_x = 5'(x);
        tgt_y = 5'(y);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        n = 1;
        ovf_at_start = sel ? int'(overflow_b) : int'(overflow_a);
        while (!(sel ? done_b : done_a) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("flood_done_seen", sel ? int'(done_b) : int'(done_a), 1);
    endtask

    task automatic query(input int x, input int y, output int dir);
        qry_x = 5'(x);
        qry_y = 5'(y);
        @(negedge clk);
        dir = int'(qry_dir_a);
    endtask

    task automatic walk(input int sx, input int sy, output int n);
        int x = sx;
        int y = sy;
        int dir;
        n = 0;
        query(x, y, dir);
        while (dir != 5 && dir < 4 && n < 200) begin
            case (dir)
                0: y--;
                1: x--;
                2: y++;
                default: x++;
            endcase
            n++;
            query(x, y, dir);
        end
        check_eq("walk_end_dir", dir, 5);
    endtask

    initial begin
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        tgt_x   = '0;
        tgt_y   = '0;
        qry_x   = '0;
        qry_y   = '0;

        @(negedge clk);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);
        check_eq("rst_path_valid", path_valid_a, 0);
        check_eq("rst_overflow", overflow_a, 0);
        check_eq("rst_qry_dir", qry_dir_a, 4);
        check_eq("rst_map_x", map_x_a, 0);
        check_eq("rst_map_y", map_y_a, 0);
        reset = 1'b1;
        @(negedge clk);

        // Open box, target (2,2): 729 interior cells at 5 cycles each.
        wall_mode = 0;
        run_flood(1'b0, 2, 2, cycles);
        check_eq("open_cycles", cycles, 4672);
        check_eq("open_busy_at_done", busy_a, 0);
        check_eq("open_path_valid", path_valid_a, 1);
        check_eq("open_overflow", overflow_a, 0);
        @(negedge clk);
        check_eq("open_done_pulse", done_a, 0);
        query(27, 27, d);
        check_range("open_q_27_27", d, 0, 1);
        query(2, 2, d);
        check_eq("open_q_tgt", d, 5);
        query(3, 2, d);
        check_eq("open_q_3_2", d, 1);
        query(2, 3, d);
        check_eq("open_q_2_3", d, 0);
        query(0, 5, d);
        check_eq("open_q_oob", d, 4);
        walk(27, 27, steps);
        check_eq("open_walk_steps", steps, 50);

        // Blocking wall column at x=10: only 9x27 cells reachable.
        wall_mode = 1;
        run_flood(1'b0, 2, 2, cycles);
        check_eq("wall_cycles", cycles, 2242);
        @(negedge clk);
        query(15, 5, d);
        check_eq("wall_q_15_5", d, 4);
        query(10, 5, d);
        check_eq("wall_q_on_wall", d, 4);
        query(9, 5, d);
        check_range("wall_q_9_5", d, 0, 3);
        walk(9, 5, steps);
        check_eq("wall_walk_steps", steps, 10);

        // Out-of-bounds target: CLEAR, SEED, then straight to DONE.
        wall_mode = 0;
        run_flood(1'b0, 0, 5, cycles);
        check_eq("oob_cycles", cycles, 1026);
        check_eq("oob_path_valid", path_valid_a, 1);
        check_eq("oob_overflow", overflow_a, 0);
        @(negedge clk);
        query(2, 2, d);
        check_eq("oob_q_2_2", d, 4);
        query(27, 27, d);
        check_eq("oob_q_27_27", d, 4);
        query(0, 5, d);
        check_eq("oob_q_tgt", d, 4);

        // Four-entry queue overflows on the open grid; next start clears it.
        run_flood(1'b1, 2, 2, cycles);
        check_eq("smallq_overflow", overflow_b, 1);
        check_eq("smallq_path_valid", path_valid_b, 1);
        @(negedge clk);
        run_flood(1'b1, 0, 5, cycles);
        check_eq("smallq_ovf_after_start", ovf_at_start, 0);
        check_eq("smallq_ovf_after_done", overflow_b, 0);
        check_eq("smallq_oob_cycles", cycles, 1026);
        @(negedge clk);

        // Starts pulsed while busy and on the DONE cycle are ignored.
        qry_x = 5'd2;
        qry_y = 5'd2;
        tgt_x = 5'd2;
        tgt_y = 5'd2;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cycles = 1;
        while (!done_a && cycles < 20000) begin
            start_a = (cycles == 10 || cycles == 2000) ? 1'b1 : 1'b0;
            tgt_x = (cycles == 2000) ? 5'd0 : 5'd2;
            @(negedge clk);
            cycles++;
            if (cycles == 3000) begin
                check_eq("busy_qry_dir", qry_dir_a, 4);
                check_eq("busy_path_valid", path_valid_a, 0);
                check_eq("busy_flag", busy_a, 1);
            end
        end
        start_a = 1'b0;
        check_eq("ignored_start_cycles", cycles, 4672);
        check_eq("ignored_start_done", done_a, 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check_eq("done_start_busy", busy_a, 0);
        check_eq("done_start_done", done_a, 0);
        @(negedge clk);
        check_eq("done_start_busy2", busy_a, 0);
        query(2, 2, d);
        check_eq("after_ignored_q_tgt", d, 5);

        // Reset asserted in the middle of a flood.
        tgt_x = 5'd2;
        tgt_y = 5'd2;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (1500) @(negedge clk);
        check_eq("midrst_busy_before", busy_a, 1);
        reset = 1'b0;
        #1;
        check_eq("midrst_busy", busy_a, 0);
        check_eq("midrst_done", done_a, 0);
        check_eq("midrst_path_valid", path_valid_a, 0);
        check_eq("midrst_overflow", overflow_a, 0);
        check_eq("midrst_qry_dir", qry_dir_a, 4);
        check_eq("midrst_map_x", map_x_a, 0);
        check_eq("midrst_map_y", map_y_a, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        query(2, 2, d);
        check_eq("midrst_q_after", d, 4);
        check_eq("midrst_idle", busy_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
